sdram_port_arbiter: RTL and testbench

Shares the single request port of the SDRAM controller among three requesters: port 0 is video/line-fetch, port 1 is the CPU, port 2 is DMA/audio. Port 0 has fixed priority, with a bounded-starvation guarantee for ports 1 and 2, which are served round-robin between themselves. Up to OUTSTANDING reads may be in flight. An ID FIFO routes each read response back to the port that issued it. The block sits between the requesters and the SDRAM controller inside xgsoc, in the SDRAM clock domain.

---
 rtl/sdram_port_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of the SDRAM controller request port.
// Port 0 (video) has fixed priority with a bounded burst; ports 1 and 2 share
// round-robin. Read IDs are queued so in-order read data returns to its issuer.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned OUTSTANDING = 4,
    parameter int unsigned BURST_MAX   = 8
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic [2:0]              req_valid_i,
    output logic [2:0]              req_ready_o,
    input  logic [2:0]              req_we_i,
    input  logic [3*ADDR_W-1:0]     req_addr_i,
    input  logic [3*DATA_W-1:0]     req_wdata_i,
    input  logic [3*(DATA_W/8)-1:0] req_wmask_i,
    output logic [2:0]              rsp_valid_o,
    output logic [DATA_W-1:0]       rsp_rdata_o,
    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [DATA_W-1:0]       mem_wdata_o,
    output logic [DATA_W/8-1:0]     mem_wmask_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_W-1:0]       mem_rdata_i,
    output logic                    err_o
);

    localparam int unsigned MaskW = DATA_W / 8;
    localparam int unsigned PtrW  = $clog2(OUTSTANDING);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BcW   = $clog2(BURST_MAX + 1);
    localparam logic [CntW-1:0] FifoFull = CntW'(OUTSTANDING);
    localparam logic [BcW-1:0]  BurstLim = BcW'(BURST_MAX);

    // Arbitration signals
    logic              reg_free;
    logic              rd_room;
    logic [2:0]        elig;
    logic              others_elig;
    logic [2:0]        rr_pick;
    logic [2:0]        gnt;
    logic [1:0]        gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MaskW-1:0]  sel_wmask;
    logic              push;
    logic              pop;

    // State
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [MaskW-1:0]  mem_wmask_q, mem_wmask_d;
    logic              rr_q, rr_d;          // 0: port 1 searched first, 1: port 2
    logic [BcW-1:0]    burst_q, burst_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]        fifo_q [OUTSTANDING];
    logic [1:0]        fifo_d [OUTSTANDING];
    logic [2:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              err_q, err_d;

    // Eligibility and grant selection; a same-cycle pop does not open a read slot
    always_comb begin
        reg_free = !mem_valid_q || mem_ready_i;
        rd_room  = cnt_q < FifoFull;
        for (int n = 0; n < 3; n++) begin
            elig[n] = req_valid_i[n] && (req_we_i[n] || rd_room);
        end
        others_elig = elig[1] || elig[2];
        if (!rr_q) begin
            rr_pick = elig[1] ? 3'b010 : (elig[2] ? 3'b100 : 3'b000);
        end else begin
            rr_pick = elig[2] ? 3'b100 : (elig[1] ? 3'b010 : 3'b000);
        end
        gnt = 3'b000;
        if (reg_free) begin
            if (elig[0] && !(burst_q == BurstLim && others_elig)) begin
                gnt = 3'b001;
            end else begin
                gnt = rr_pick;
            end
        end
    end

    // Route the granted port's request fields
    always_comb begin
        gnt_id    = 2'd0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int n = 0; n < 3; n++) begin
            if (gnt[n]) begin
                gnt_id    = 2'(n);
                sel_we    = req_we_i[n];
                sel_addr  = req_addr_i[n*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata_i[n*DATA_W +: DATA_W];
                sel_wmask = req_wmask_i[n*MaskW +: MaskW];
            end
        end
    end

    assign push = (|gnt) && !sel_we;
    assign pop  = mem_rvalid_i && (cnt_q != '0);

    // Output register, round-robin pointer and port-0 burst counter
    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        rr_d        = rr_q;
        burst_d     = burst_q;
        if (reg_free) begin
            mem_valid_d = |gnt;
            if (|gnt) begin
                mem_we_d    = sel_we;
                mem_addr_d  = sel_addr;
                mem_wdata_d = sel_wdata;
                mem_wmask_d = sel_wmask;
            end
        end
        if (gnt[0]) begin
            // Only count port-0 grants that actually made someone wait
            if (!others_elig) begin
                burst_d = '0;
            end else if (burst_q != BurstLim) begin
                burst_d = burst_q + BcW'(1);
            end
        end else if (gnt[1] || gnt[2]) begin
            burst_d = '0;
            rr_d    = gnt[1];
        end
    end

    // Read-ID FIFO, response strobe and sticky error
    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 3'b000;
        rsp_rdata_d = rsp_rdata_q;
        if (push) begin
            fifo_d[wr_ptr_q] = gnt_id;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d                    = rd_ptr_q + PtrW'(1);
            rsp_valid_d[fifo_q[rd_ptr_q]] = 1'b1;
            rsp_rdata_d                 = mem_rdata_i;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
        err_d = err_q || (mem_rvalid_i && (cnt_q == '0));
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rr_q        <= 1'b0;
            burst_q     <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_q      <= '{default: 2'd0};
            rsp_valid_q <= 3'b000;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            rr_q        <= rr_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_q      <= fifo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    // Accept strobe is combinational, so hold it off while reset is asserted
    assign req_ready_o = gnt & {3{reset_n_i}};
    assign mem_valid_o = mem_valid_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: bench-side memory model plus a response
// scoreboard; expected ports are queued at grant time, data when rvalid is driven.
module tb_sdram_port_arbiter;

    localparam int unsigned ADDR_W      = 24;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned OUTSTANDING = 4;
    localparam int unsigned BURST_MAX   = 8;
    localparam int unsigned MASK_W      = DATA_W / 8;

    logic                     clk = 1'b0;
    logic                     reset_n_i = 1'b1;
    logic [2:0]               req_valid_i = '0;
    logic [2:0]               req_ready_o;
    logic [2:0]               req_we_i = '0;
    logic [3*ADDR_W-1:0]      req_addr_i = '0;
    logic [3*DATA_W-1:0]      req_wdata_i = '0;
    logic [3*MASK_W-1:0]      req_wmask_i = '0;
    logic [2:0]               rsp_valid_o;
    logic [DATA_W-1:0]        rsp_rdata_o;
    logic                     mem_valid_o;
    logic                     mem_ready_i = 1'b1;
    logic                     mem_we_o;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [DATA_W-1:0]        mem_wdata_o;
    logic [MASK_W-1:0]        mem_wmask_o;
    logic                     mem_rvalid_i = 1'b0;
    logic [DATA_W-1:0]        mem_rdata_i = '0;
    logic                     err_o;

    sdram_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .OUTSTANDING (OUTSTANDING),
        .BURST_MAX   (BURST_MAX)
    ) dut (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_wmask_i  (req_wmask_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .mem_valid_o  (mem_valid_o),
        .mem_ready_i  (mem_ready_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]        mask;
        logic [DATA_W-1:0] data;
    } rsp_t;

    rsp_t exp_rsp_q[$];
    int   exp_port_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   auto_rsp = 1'b0;
    int   rd_order [4] = '{0, 1, 2, 1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
        return {8'hC3, a} ^ 32'h0F0F_F0F0;
    endfunction

    task automatic set_req(input int p, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        req_valid_i[p]                   = 1'b1;
        req_we_i[p]                      = we;
        req_addr_i[p*ADDR_W +: ADDR_W]   = a;
        req_wdata_i[p*DATA_W +: DATA_W]  = d;
        req_wmask_i[p*MASK_W +: MASK_W]  = m;
    endtask

    // Memory returns read data; pair it with the port the bench expects next
    task automatic drive_rvalid(input logic [DATA_W-1:0] d);
        rsp_t e;
        int   p;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        if (exp_port_q.size() > 0) begin
            p      = exp_port_q.pop_front();
            e.mask = 3'b001 << p;
            e.data = d;
            exp_rsp_q.push_back(e);
        end
    endtask

    // One clock: model the controller, then score any response strobe at negedge
    task automatic step();
        logic              acc;
        logic [ADDR_W-1:0] a;
        rsp_t              e;
        acc = auto_rsp && mem_valid_o && mem_ready_i && !mem_we_o;
        a   = mem_addr_o;
        @(posedge clk);
        #1;
        mem_rvalid_i = 1'b0;
        if (acc) drive_rvalid(data_of(a));
        @(negedge clk);
        if (rsp_valid_o != 3'b000) begin
            if (exp_rsp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
            end else begin
                e = exp_rsp_q.pop_front();
                check("rsp_port", 64'(rsp_valid_o), 64'(e.mask));
                check("rsp_data", 64'(rsp_rdata_o), 64'(e.data));
            end
        end
    endtask

    task automatic apply_reset();
        check("rsp_drained", 64'(exp_rsp_q.size()), 64'd0);
        reset_n_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        exp_port_q.delete();
        exp_rsp_q.delete();
        #1;
        check("rst_mem", 64'({mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o}), 64'd0);
        check("rst_ctl", 64'({req_ready_o, rsp_valid_o, err_o}), 64'd0);
        check("rst_rdata", 64'(rsp_rdata_o), 64'd0);
        step();
        step();
        reset_n_i = 1'b1;
    endtask

    initial begin
        #2;
        apply_reset();

        // Single read from port 1
        set_req(1, 1'b0, 24'h000123, '0, '0);
        #1;
        check("rd1_ready", 64'(req_ready_o), 64'b010);
        check("rd1_mv_lat", 64'(mem_valid_o), 64'd0);
        exp_port_q.push_back(1);
        step();
        req_valid_i = '0;
        check("rd1_mem", 64'({mem_valid_o, mem_we_o, mem_addr_o}), 64'({1'b1, 1'b0, 24'h000123}));
        step();
        check("rd1_mv_drop", 64'(mem_valid_o), 64'd0);
        drive_rvalid(32'hDEADBEEF);
        step();
        step();
        check("rd1_strobe_len", 64'(rsp_valid_o), 64'd0);
        check("rd1_hold", 64'(rsp_rdata_o), 64'hDEADBEEF);

        // Continuous reads from all ports: 0 x8, then one round-robin grant
        apply_reset();
        auto_rsp = 1'b1;
        for (int p = 0; p < 3; p++) set_req(p, 1'b0, 24'(p * 16 + 7), '0, '0);
        for (int k = 0; k < 36; k++) begin
            int g;
            g = (k % 9 != 8) ? 0 : (((k / 9) % 2 == 0) ? 1 : 2);
            #1;
            check("gnt_seq", 64'(req_ready_o), 64'(3'b001 << g));
            exp_port_q.push_back(g);
            step();
        end
        req_valid_i = '0;
        repeat (4) step();
        auto_rsp = 1'b0;

        // FIFO full blocks reads but not writes; responses route in issue order
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(rd_order[i], 1'b0, 24'(32'h200 + i), '0, '0);
            #1;
            check("full_issue", 64'(req_ready_o), 64'(3'b001 << rd_order[i]));
            exp_port_q.push_back(rd_order[i]);
            step();
            req_valid_i = '0;
        end
        set_req(1, 1'b0, 24'h000300, '0, '0);
        set_req(2, 1'b1, 24'h000301, 32'hCAFE0001, 4'hF);
        #1;
        check("full_wr_only", 64'(req_ready_o), 64'b100);
        step();
        req_valid_i[2] = 1'b0;
        check("full_wr_out", 64'({mem_valid_o, mem_we_o, mem_addr_o}), 64'({1'b1, 1'b1, 24'h000301}));
        #1;
        check("full_rd_held", 64'(req_ready_o), 64'd0);
        step();
        req_valid_i = '0;
        for (int i = 0; i < 4; i++) begin
            drive_rvalid(32'h1000_0000 + i);
            step();
        end
        check("full_rsp_done", 64'(exp_rsp_q.size() + exp_port_q.size()), 64'd0);

        // Back-pressure: outputs hold while mem_ready_i is low
        apply_reset();
        mem_ready_i = 1'b0;
        set_req(0, 1'b1, 24'h00ABCD, 32'h55AA55AA, 4'b0101);
        #1;
        check("stall_first", 64'(req_ready_o), 64'b001);
        step();
        req_valid_i[0] = 1'b0;
        set_req(1, 1'b1, 24'h000777, 32'h12345678, 4'hF);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_ready", 64'(req_ready_o), 64'd0);
            check("stall_out", 64'({mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o}),
                  64'({1'b1, 1'b1, 24'h00ABCD, 32'h55AA55AA, 4'b0101}));
            step();
        end
        mem_ready_i = 1'b1;
        #1;
        check("stall_accept", 64'(req_ready_o), 64'b010);
        step();
        req_valid_i = '0;
        check("stall_next", 64'({mem_valid_o, mem_addr_o}), 64'({1'b1, 24'h000777}));
        step();

        // Read data with an empty ID FIFO
        apply_reset();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0BAD0;
        step();
        check("err_set", 64'(err_o), 64'd1);
        check("err_no_rsp", 64'(rsp_valid_o), 64'd0);
        repeat (3) step();
        check("err_sticky", 64'(err_o), 64'd1);
        reset_n_i = 1'b0;
        #1;
        check("err_clear", 64'(err_o), 64'd0);

        // Reset with reads in flight, then a fresh read must route correctly
        apply_reset();
        set_req(2, 1'b0, 24'h000400, '0, '0);
        #1;
        check("mid_rd0", 64'(req_ready_o), 64'b100);
        step();
        req_valid_i = '0;
        set_req(0, 1'b0, 24'h000401, '0, '0);
        #1;
        check("mid_rd1", 64'(req_ready_o), 64'b001);
        step();
        req_valid_i = '0;
        set_req(1, 1'b0, 24'h000402, '0, '0);
        apply_reset();
        #1;
        check("post_rst_issue", 64'(req_ready_o), 64'b010);
        exp_port_q.push_back(1);
        step();
        req_valid_i = '0;
        step();
        drive_rvalid(32'h600DF00D);
        step();
        step();
        check("rsp_leftover", 64'(exp_rsp_q.size() + exp_port_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
